word_serial_tx: RTL and testbench
=================================

Name: word_serial_tx

Overview:
Parallel-to-serial word transmitter. It accepts one DATA_W-bit word per valid/ready handshake and drives it onto a single-wire serial line as a framed bit stream: start bit, then data LSB first, then stop bit. Each bit is held for CLKS_PER_BIT clocks. It is the transmit end paired with the team's serial word receiver and sits between a parallel producer and the serial link pin.

Parameters:
DATA_W, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clk cycles each serial bit is held (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  producer has a word on in_data
in_ready  output  1  transmitter can accept a word (high only in IDLE)
in_data  input  DATA_W  word to send, sampled on handshake edge only
ser_out  output  1  serial line, registered, idles high
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, frame fully transmitted

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, ser_out=1, done=0, busy=0, in_ready=1. Shift register and counters are cleared.
- in_ready = (state==IDLE). busy = !in_ready. Both are decoded combinationally from the state register.
- Handshake: a word is accepted on a rising edge where in_valid && in_ready. in_data is captured into the shift register; in_data is ignored at all other times.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: ser_out=1. On accept, go to START.
- START: ser_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: ser_out=shift[0]. After each CLKS_PER_BIT cycles, shift right by one and increment the bit counter. After DATA_W bits, go to PARITY (if enabled) or STOP.
- STOP: ser_out=1 for CLKS_PER_BIT cycles, then go to IDLE with done=1 for exactly that first IDLE cycle.
- Timing: ser_out first goes low in the cycle after the accept edge. The edge that raises done comes exactly FRAME_BITS*CLKS_PER_BIT edges after the accept edge. FRAME_BITS = DATA_W+2 (+1 with parity).
- Back-to-back: an accept is legal in the done cycle. The minimum accept-to-accept spacing is FRAME_BITS*CLKS_PER_BIT+1 edges, so there is exactly one idle-high cycle between frames.
- Bit-period counter: width $clog2(CLKS_PER_BIT)+1. It counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary. CLKS_PER_BIT=1 gives one bit per clock with no special case.
- Bit counter: width $clog2(DATA_W)+1. It does not wrap within a frame.
- in_valid while busy: no effect, and the word is not lost (the producer holds it per the valid/ready rule).
- Reset mid-frame: the frame is aborted immediately. ser_out=1 asynchronously, no done pulse, and the partial word is discarded.
- ser_out is glitch-free: it is driven from a flop, never decoded combinationally.

Optional Feature:
Macro WORD_SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even parity bit (XOR of the captured word) for CLKS_PER_BIT cycles, and FRAME_BITS=DATA_W+3.
- Undefined: no PARITY state and no parity logic, and FRAME_BITS=DATA_W+2.

Test Plan:
1. Assert rst low for 3 cycles, then release -> ser_out=1, in_ready=1, busy=0, done=0 during and after reset.
2. DATA_W=8, CLKS_PER_BIT=4, send 0xA5 -> ser_out bits, each held 4 cycles: 0,1,0,1,0,0,1,0,1,1. busy=1 for 40 cycles. done pulses once, 40 edges after accept.
3. Hold in_valid with 0x3C, then switch to 0xC3 immediately after the first accept and change in_data mid-frame -> the first frame carries 0x3C unchanged. 0xC3 is accepted in the done cycle, 41 edges after the first accept, with a single idle-high cycle between frames.
4. Pull rst low during DATA bit 3 of 0xFF -> ser_out=1 and in_ready=1 asynchronously, no done. The next word 0x00 is sent correctly after release.
5. With WORD_SERIAL_TX_PARITY_EN: send 0x07 -> parity bit 1 and done at 44 edges. Send 0x03 -> parity bit 0.
6. CLKS_PER_BIT=1, send 0xFF -> ser_out = 0 then 1 for 9 cycles. done 10 edges after accept.

Source files
------------

// File: rtl/word_serial_tx.sv
// Framed parallel-to-serial word transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Optional even parity bit before the stop bit when WORD_SERIAL_TX_PARITY_EN is defined.
module word_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_out,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef WORD_SERIAL_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              ser_q, ser_d;
    logic              done_q, done_d;
    logic              bit_end_s;

`ifdef WORD_SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;

    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction
`endif

    assign bit_end_s = (cnt_q == CNT_LAST);
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign ser_out   = ser_q;
    assign done      = done_q;

    // Next-state, counter, shifter and serial-bit decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
`ifdef WORD_SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d  = S_START;
                    shift_d  = in_data;
                    cnt_d    = {CW{1'b0}};
                    bit_d    = {BW{1'b0}};
`ifdef WORD_SERIAL_TX_PARITY_EN
                    parity_d = even_parity(in_data);
`endif
                end else begin
                    cnt_d = {CW{1'b0}};
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_d = S_DATA;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    cnt_d = {CW{1'b0}};
                    if (bit_q == BIT_LAST) begin
`ifdef WORD_SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef WORD_SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) begin
                    state_d = S_STOP;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    state_d = S_IDLE;
                    cnt_d   = {CW{1'b0}};
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
                bit_d   = {BW{1'b0}};
                shift_d = {DATA_W{1'b0}};
            end
        endcase

        // Line level follows the state being entered so the flop output lines up with it.
        case (state_d)
            S_IDLE:   ser_d = 1'b1;
            S_START:  ser_d = 1'b0;
            S_DATA:   ser_d = shift_d[0];
`ifdef WORD_SERIAL_TX_PARITY_EN
            S_PARITY: ser_d = parity_d;
`endif
            S_STOP:   ser_d = 1'b1;
            default:  ser_d = 1'b1;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            bit_q    <= {BW{1'b0}};
            shift_q  <= {DATA_W{1'b0}};
            ser_q    <= 1'b1;
            done_q   <= 1'b0;
`ifdef WORD_SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            ser_q    <= ser_d;
            done_q   <= done_d;
`ifdef WORD_SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_word_serial_tx.sv
// Randomized self-checking bench for word_serial_tx: two instances (4 and 1 clocks per bit)
// checked cycle by cycle against a frame-level reference model.
module tb_word_serial_tx;

`ifdef WORD_SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid_0, in_valid_1;
    logic       in_ready_0, in_ready_1;
    logic [7:0] in_data;
    logic       ser_0, ser_1;
    logic       busy_0, busy_1;
    logic       done_0, done_1;
    int         cur_sel;
    int         n_vec;
    int         n_err;

    logic ser_s, busy_s, done_s, rdy_s;
    assign ser_s  = (cur_sel == 0) ? ser_0 : ser_1;
    assign busy_s = (cur_sel == 0) ? busy_0 : busy_1;
    assign done_s = (cur_sel == 0) ? done_0 : done_1;
    assign rdy_s  = (cur_sel == 0) ? in_ready_0 : in_ready_1;

    word_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_0), .in_ready(in_ready_0),
        .in_data(in_data), .ser_out(ser_0), .busy(busy_0), .done(done_0)
    );

    word_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .in_data(in_data), .ser_out(ser_1), .busy(busy_1), .done(done_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: level of frame bit idx for word w (start, data LSB first, [parity], stop).
    function automatic logic [31:0] frame_bit(input logic [7:0] w, input int idx);
        if (idx == 0) return 32'd0;
        if (idx <= 8) return 32'((w >> (idx - 1)) & 8'd1);
`ifdef WORD_SERIAL_TX_PARITY_EN
        if (idx == 9) return 32'(^w);
`endif
        return 32'd1;
    endfunction

    task automatic drive(input int sel, input logic v);
        in_valid_0 = (sel == 0) ? v : 1'b0;
        in_valid_1 = (sel == 1) ? v : 1'b0;
    endtask

    // Send one word and check every cycle of its frame plus the done cycle.
    task automatic run_frame(input int sel, input logic [7:0] w, input bit keep_valid,
                             input logic [7:0] next_w);
        int cpb;
        int ncyc;
        cur_sel = sel;
        cpb  = (sel == 0) ? 4 : 1;
        ncyc = FRAME_BITS * cpb;
        #0;
        check("ready_before", 32'(rdy_s), 32'd1);
        drive(sel, 1'b1);
        in_data = w;
        @(posedge clk); #1;
        for (int k = 1; k <= ncyc; k++) begin
            if (keep_valid && k == ncyc) in_data = next_w;
            else in_data = 8'($urandom);
            drive(sel, keep_valid);
            check("ser", 32'(ser_s), frame_bit(w, (k - 1) / cpb));
            check("busy", 32'(busy_s), 32'd1);
            check("done_early", 32'(done_s), 32'd0);
            @(posedge clk); #1;
        end
        check("done", 32'(done_s), 32'd1);
        check("busy_done", 32'(busy_s), 32'd0);
        check("ready_done", 32'(rdy_s), 32'd1);
        check("ser_done", 32'(ser_s), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        drive(cur_sel, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_ser", 32'(ser_s), 32'd1);
            check("idle_busy", 32'(busy_s), 32'd0);
            check("idle_done", 32'(done_s), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] nxt;
        bit         keep;
        n_vec   = 0;
        n_err   = 0;
        cur_sel = 0;
        rst     = 1'b0;
        in_data = 8'h00;
        drive(0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            cur_sel = s;
            #0;
            check("rst_ser", 32'(ser_s), 32'd1);
            check("rst_ready", 32'(rdy_s), 32'd1);
            check("rst_busy", 32'(busy_s), 32'd0);
            check("rst_done", 32'(done_s), 32'd0);
        end
        cur_sel = 0;
        rst = 1'b1;
        idle_cycles(2);

        run_frame(0, 8'hA5, 1'b0, 8'h00);
        idle_cycles(2);

        run_frame(0, 8'h3C, 1'b1, 8'hC3);
        run_frame(0, 8'hC3, 1'b0, 8'h00);
        idle_cycles(2);

        // Abort a frame of 0xFF during data bit 3.
        drive(0, 1'b1);
        in_data = 8'hFF;
        @(posedge clk); #1;
        drive(0, 1'b0);
        repeat (16) @(posedge clk);
        #1;
        check("abort_pre_ser", 32'(ser_0), 32'd1);
        check("abort_pre_busy", 32'(busy_0), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_ser", 32'(ser_0), 32'd1);
        check("abort_ready", 32'(in_ready_0), 32'd1);
        check("abort_busy", 32'(busy_0), 32'd0);
        check("abort_done", 32'(done_0), 32'd0);
        @(posedge clk); #1;
        check("abort_done2", 32'(done_0), 32'd0);
        rst = 1'b1;
        idle_cycles(2);
        run_frame(0, 8'h00, 1'b0, 8'h00);
        idle_cycles(1);

        run_frame(0, 8'h07, 1'b0, 8'h00);
        idle_cycles(1);
        run_frame(0, 8'h03, 1'b0, 8'h00);
        idle_cycles(1);

        w = 8'($urandom);
        for (int i = 0; i < 12; i++) begin
            keep = (i < 11) && ($urandom_range(0, 1) == 32'd1);
            nxt  = 8'($urandom);
            run_frame(0, w, keep, nxt);
            if (keep) begin
                w = nxt;
            end else begin
                idle_cycles(int'($urandom_range(1, 3)));
                w = 8'($urandom);
            end
        end

        run_frame(1, 8'hFF, 1'b0, 8'h00);
        idle_cycles(1);
        w = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            keep = (i < 7) && ($urandom_range(0, 1) == 32'd1);
            nxt  = 8'($urandom);
            run_frame(1, w, keep, nxt);
            if (keep) begin
                w = nxt;
            end else begin
                idle_cycles(1);
                w = 8'($urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
